// File: rtl/ttt_pkg.sv
// Shared codes for the tic-tac-toe board: square status, player, winner,
// win-line geometry and the turn-controller state encoding.
package ttt_pkg;

   localparam int NUM_SQUARES = 9;
   localparam int NUM_LINES   = 8;

   localparam logic [2:0] BLANK     = 3'd0;
   localparam logic [2:0] MARKER_P1 = 3'd1;
   localparam logic [2:0] MARKER_P2 = 3'd2;

   localparam logic PLAYER_1 = 1'b0;
   localparam logic PLAYER_2 = 1'b1;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Zero-based square indices: rows, then columns, then both diagonals.
   localparam int WIN_LINES [NUM_LINES][3] = '{
      '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
      '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
      '{0, 4, 8}, '{2, 4, 6}
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_COMMIT,
      ST_WAIT,
      ST_EVAL,
      ST_DONE
   } turn_state_t;

   // Cursor moves one square with wrap-around across 1..9.
   function automatic logic [7:0] cursorStep(input logic [7:0] cur, input logic ccw);
      logic [7:0] nxt;
      if (ccw) begin
         nxt = (cur <= 8'd1 || cur > 8'd9) ? 8'd9 : cur - 8'd1;
      end else begin
         nxt = (cur >= 8'd9) ? 8'd1 : cur + 8'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational board evaluator: finds a completed line of one player's marks
// and flags a board with no blank squares left.
module ttt_win_detect
   import ttt_pkg::*;
(
   input  logic [3*NUM_SQUARES-1:0] i_status,
   output logic [1:0]               o_winner,
   output logic                     o_boardFull
);

   always_comb begin
      o_winner    = WIN_NONE;
      o_boardFull = 1'b1;
      for (int s = 0; s < NUM_SQUARES; s++) begin
         if (i_status[3*s +: 3] == BLANK) begin
            o_boardFull = 1'b0;
         end
      end
      // First matching line wins; only real player marks count as a line.
      for (int l = 0; l < NUM_LINES; l++) begin
         if (o_winner == WIN_NONE &&
             i_status[3*WIN_LINES[l][0] +: 3] == i_status[3*WIN_LINES[l][1] +: 3] &&
             i_status[3*WIN_LINES[l][1] +: 3] == i_status[3*WIN_LINES[l][2] +: 3]) begin
            if (i_status[3*WIN_LINES[l][0] +: 3] == MARKER_P1) begin
               o_winner = WIN_P1;
            end else if (i_status[3*WIN_LINES[l][0] +: 3] == MARKER_P2) begin
               o_winner = WIN_P2;
            end
         end
      end
   end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Turn controller: rotary-encoder cursor, guarded move commit, player alternation
// and end-of-game detection against the board status inputs.
module ttt_turn_ctrl
   import ttt_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       rot_a,
   input  logic       rot_b,
   input  logic       rot_press,
   input  logic [2:0] square_1_status,
   input  logic [2:0] square_2_status,
   input  logic [2:0] square_3_status,
   input  logic [2:0] square_4_status,
   input  logic [2:0] square_5_status,
   input  logic [2:0] square_6_status,
   input  logic [2:0] square_7_status,
   input  logic [2:0] square_8_status,
   input  logic [2:0] square_9_status,
   output logic [7:0] square_num,
   output logic       rot_ctr,
   output logic       player_turn,
   output logic       move_rej,
   output logic       game_over,
   output logic [1:0] winner
);

   logic [SYNC_STAGES-1:0] r_aSync;
   logic [SYNC_STAGES-1:0] r_bSync;
   logic [SYNC_STAGES-1:0] r_pressSync;
   logic                   r_aPrev;
   logic                   r_pressPrev;

   turn_state_t r_state;
   turn_state_t w_nextState;

   logic [7:0] r_squareNum;
   logic       r_rotCtr;
   logic       r_playerTurn;
   logic       r_moveRej;
   logic       r_gameOver;
   logic [1:0] r_winner;

   logic [7:0] w_nextSquare;
   logic       w_nextRotCtr;
   logic       w_nextTurn;
   logic       w_nextMoveRej;
   logic       w_nextGameOver;
   logic [1:0] w_nextWinner;

   logic                     w_aEdge;
   logic                     w_pressEdge;
   logic                     w_bSynced;
   logic [2:0]               w_target;
   logic [3*NUM_SQUARES-1:0] w_board;
   logic [1:0]               w_lineWinner;
   logic                     w_boardFull;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_aSync     <= '0;
         r_bSync     <= '0;
         r_pressSync <= '0;
         r_aPrev     <= 1'b0;
         r_pressPrev <= 1'b0;
      end else begin
         r_aSync[0]     <= rot_a;
         r_bSync[0]     <= rot_b;
         r_pressSync[0] <= rot_press;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_aSync[i]     <= r_aSync[i-1];
            r_bSync[i]     <= r_bSync[i-1];
            r_pressSync[i] <= r_pressSync[i-1];
         end
         r_aPrev     <= r_aSync[SYNC_STAGES-1];
         r_pressPrev <= r_pressSync[SYNC_STAGES-1];
      end
   end

   assign w_aEdge     = r_aSync[SYNC_STAGES-1] & ~r_aPrev;
   assign w_pressEdge = r_pressSync[SYNC_STAGES-1] & ~r_pressPrev;
   assign w_bSynced   = r_bSync[SYNC_STAGES-1];

   assign w_board = {square_9_status, square_8_status, square_7_status,
                     square_6_status, square_5_status, square_4_status,
                     square_3_status, square_2_status, square_1_status};

   ttt_win_detect u_winDetect (
      .i_status    (w_board),
      .o_winner    (w_lineWinner),
      .o_boardFull (w_boardFull)
   );

   // An impossible cursor value reads as occupied so a stray index never commits.
   always_comb begin
      w_target = 3'b111;
      case (r_squareNum)
         8'd1: w_target = square_1_status;
         8'd2: w_target = square_2_status;
         8'd3: w_target = square_3_status;
         8'd4: w_target = square_4_status;
         8'd5: w_target = square_5_status;
         8'd6: w_target = square_6_status;
         8'd7: w_target = square_7_status;
         8'd8: w_target = square_8_status;
         8'd9: w_target = square_9_status;
         default: w_target = 3'b111;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_nextSquare   = r_squareNum;
      w_nextRotCtr   = 1'b0;
      w_nextTurn     = r_playerTurn;
      w_nextMoveRej  = 1'b0;
      w_nextGameOver = r_gameOver;
      w_nextWinner   = r_winner;
      case (r_state)
         ST_IDLE: begin
            // A press takes priority; a coincident detent is simply lost.
            if (w_pressEdge) begin
               w_nextState = ST_CHECK;
            end else if (w_aEdge) begin
               w_nextSquare = cursorStep(r_squareNum, w_bSynced);
            end
         end
         ST_CHECK: begin
            if (w_target != BLANK) begin
               w_nextMoveRej = 1'b1;
               w_nextState   = ST_IDLE;
            end else begin
               w_nextRotCtr = 1'b1;
               w_nextState  = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            w_nextState = ST_EVAL;
         end
         ST_EVAL: begin
            if (w_lineWinner != WIN_NONE) begin
               w_nextWinner   = w_lineWinner;
               w_nextGameOver = 1'b1;
               w_nextState    = ST_DONE;
            end else if (w_boardFull) begin
               w_nextWinner   = WIN_DRAW;
               w_nextGameOver = 1'b1;
               w_nextState    = ST_DONE;
            end else begin
               w_nextTurn  = ~r_playerTurn;
               w_nextState = ST_IDLE;
            end
         end
         ST_DONE: begin
            w_nextState = ST_DONE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_squareNum  <= 8'd1;
         r_rotCtr     <= 1'b0;
         r_playerTurn <= PLAYER_1;
         r_moveRej    <= 1'b0;
         r_gameOver   <= 1'b0;
         r_winner     <= WIN_NONE;
      end else begin
         r_squareNum  <= w_nextSquare;
         r_rotCtr     <= w_nextRotCtr;
         r_playerTurn <= w_nextTurn;
         r_moveRej    <= w_nextMoveRej;
         r_gameOver   <= w_nextGameOver;
         r_winner     <= w_nextWinner;
      end
   end

   assign square_num  = r_squareNum;
   assign rot_ctr     = r_rotCtr;
   assign player_turn = r_playerTurn;
   assign move_rej    = r_moveRej;
   assign game_over   = r_gameOver;
   assign winner      = r_winner;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl with a simple square_status board model
// that records each committed move for the player whose turn it is.
module tb_ttt_turn_ctrl;

   logic       clk;
   logic       clr;
   logic       rot_a;
   logic       rot_b;
   logic       rot_press;
   logic [2:0] board [1:9];
   logic [7:0] square_num;
   logic       rot_ctr;
   logic       player_turn;
   logic       move_rej;
   logic       game_over;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;
   int expCursor = 1;

   ttt_turn_ctrl #(.SYNC_STAGES(2)) dut (
      .clk             (clk),
      .clr             (clr),
      .rot_a           (rot_a),
      .rot_b           (rot_b),
      .rot_press       (rot_press),
      .square_1_status (board[1]),
      .square_2_status (board[2]),
      .square_3_status (board[3]),
      .square_4_status (board[4]),
      .square_5_status (board[5]),
      .square_6_status (board[6]),
      .square_7_status (board[7]),
      .square_8_status (board[8]),
      .square_9_status (board[9]),
      .square_num      (square_num),
      .rot_ctr         (rot_ctr),
      .player_turn     (player_turn),
      .move_rej        (move_rej),
      .game_over       (game_over),
      .winner          (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board model: a commit strobe marks the cursor square for the current player.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int k = 1; k <= 9; k++) board[k] <= 3'd0;
      end else if (rot_ctr && square_num >= 8'd1 && square_num <= 8'd9) begin
         board[square_num] <= player_turn ? 3'd2 : 3'd1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int stepCursor(input int cur, input bit ccw);
      if (ccw) return (cur == 1) ? 9 : cur - 1;
      return (cur == 9) ? 1 : cur + 1;
   endfunction

   task automatic applyReset();
      @(negedge clk);
      clr = 1'b1;
      rot_a = 1'b0;
      rot_b = 1'b0;
      rot_press = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      expCursor = 1;
      @(negedge clk);
   endtask

   task automatic rotateStep(input bit ccw, input bit expectMove, input string tag);
      @(negedge clk);
      rot_b = ccw;
      @(negedge clk);
      rot_a = 1'b1;
      repeat (4) @(negedge clk);
      if (expectMove) expCursor = stepCursor(expCursor, ccw);
      checkOutput(tag, square_num, expCursor);
      rot_a = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic gotoSquare(input int target);
      int fwd;
      fwd = (target - expCursor + 9) % 9;
      if (fwd <= 4) begin
         for (int i = 0; i < fwd; i++) rotateStep(1'b0, 1'b1, "goto_cw");
      end else begin
         for (int i = 0; i < 9 - fwd; i++) rotateStep(1'b1, 1'b1, "goto_ccw");
      end
   endtask

   // mode: 0 = press ignored, 1 = commit expected, 2 = rejection expected.
   // Returns at E+4 relative to the cycle the press is detected.
   task automatic pressSquare(input string tag, input int mode);
      @(negedge clk);
      rot_press = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput({tag, "_ctr_E"}, rot_ctr, 0);
      @(negedge clk);
      checkOutput({tag, "_ctr_E1"}, rot_ctr, (mode == 1) ? 1 : 0);
      checkOutput({tag, "_rej_E1"}, move_rej, (mode == 2) ? 1 : 0);
      if (mode == 1) checkOutput({tag, "_sq_E1"}, square_num, expCursor);
      @(negedge clk);
      checkOutput({tag, "_ctr_E2"}, rot_ctr, 0);
      checkOutput({tag, "_rej_E2"}, move_rej, 0);
      rot_press = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic playMove(input int sq, input logic expTurn, input logic expOver, input logic [1:0] expWin);
      gotoSquare(sq);
      pressSquare($sformatf("move%0d", sq), 1);
      checkOutput($sformatf("move%0d_turn", sq), player_turn, expTurn);
      checkOutput($sformatf("move%0d_over", sq), game_over, expOver);
      checkOutput($sformatf("move%0d_win", sq), winner, expWin);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clr = 1'b1;
      rot_a = 1'b0;
      rot_b = 1'b0;
      rot_press = 1'b0;
      applyReset();
      checkOutput("rst_sq", square_num, 1);
      checkOutput("rst_ctr", rot_ctr, 0);
      checkOutput("rst_turn", player_turn, 0);
      checkOutput("rst_rej", move_rej, 0);
      checkOutput("rst_over", game_over, 0);
      checkOutput("rst_win", winner, 0);

      // Cursor: 1->2->3->4, then 4->3->2->1->9->8.
      for (int i = 0; i < 3; i++) rotateStep(1'b0, 1'b1, $sformatf("cw%0d", i));
      checkOutput("cw_final", square_num, 4);
      for (int i = 0; i < 5; i++) rotateStep(1'b1, 1'b1, $sformatf("ccw%0d", i));
      checkOutput("ccw_final", square_num, 8);

      // Commit on blank 5, then a rejected press on the now-occupied 5.
      gotoSquare(5);
      pressSquare("commit5", 1);
      checkOutput("commit5_turn", player_turn, 1);
      checkOutput("commit5_over", game_over, 0);
      pressSquare("reject5", 2);
      checkOutput("reject5_turn", player_turn, 1);
      checkOutput("reject5_board", board[5], 1);

      // Player 1 completes the top row.
      applyReset();
      playMove(1, 1'b1, 1'b0, 2'b00);
      playMove(4, 1'b0, 1'b0, 2'b00);
      playMove(2, 1'b1, 1'b0, 2'b00);
      playMove(5, 1'b0, 1'b0, 2'b00);
      playMove(3, 1'b0, 1'b1, 2'b01);
      rotateStep(1'b0, 1'b0, "done_rot");
      pressSquare("done_press", 0);
      checkOutput("done_win", winner, 1);
      checkOutput("done_over", game_over, 1);
      checkOutput("done_turn", player_turn, 0);

      // Full board with no line: draw.
      applyReset();
      playMove(1, 1'b1, 1'b0, 2'b00);
      playMove(2, 1'b0, 1'b0, 2'b00);
      playMove(3, 1'b1, 1'b0, 2'b00);
      playMove(5, 1'b0, 1'b0, 2'b00);
      playMove(4, 1'b1, 1'b0, 2'b00);
      playMove(6, 1'b0, 1'b0, 2'b00);
      playMove(8, 1'b1, 1'b0, 2'b00);
      playMove(7, 1'b0, 1'b0, 2'b00);
      playMove(9, 1'b0, 1'b1, 2'b11);

      // clr during COMMIT kills the strobe at once.
      applyReset();
      gotoSquare(2);
      @(negedge clk);
      rot_press = 1'b1;
      repeat (3) @(negedge clk);
      @(negedge clk);
      checkOutput("clr_pre_ctr", rot_ctr, 1);
      clr = 1'b1;
      rot_press = 1'b0;
      #1;
      checkOutput("clr_ctr", rot_ctr, 0);
      checkOutput("clr_sq", square_num, 1);
      checkOutput("clr_turn", player_turn, 0);
      checkOutput("clr_rej", move_rej, 0);
      checkOutput("clr_over", game_over, 0);
      checkOutput("clr_win", winner, 0);
      @(negedge clk);
      clr = 1'b0;
      expCursor = 1;
      repeat (2) @(negedge clk);

      // A detent whose synced edge lands in WAIT is dropped.
      gotoSquare(4);
      @(negedge clk);
      rot_b = 1'b0;
      rot_press = 1'b1;
      repeat (3) @(negedge clk);
      rot_a = 1'b1;
      @(negedge clk);
      checkOutput("wait_ctr_E1", rot_ctr, 1);
      @(negedge clk);
      rot_press = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("wait_sq_E4", square_num, 4);
      checkOutput("wait_turn_E4", player_turn, 1);
      rot_a = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("wait_sq_late", square_num, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
